fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side and FIFO-write-side signals of the write-port arbiter.
//   slave  : arbiter view (takes requests and fifo_full, drives ready, FIFO write and status)
//   master : environment view (drives requests and fifo_full, observes the rest)
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          busy;
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ producers.
//   clk, reset_n (async, active-low)
//   bus.req_valid/req_data in, bus.req_ready out  : per-producer handshake
//   bus.fifo_full in, bus.fifo_wr_en/fifo_din out : FIFO write port
//   bus.grant_id/busy out                         : current grant holder, valid while busy
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic clk,
  input logic reset_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t                state;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   last_id;
  logic [CW-1:0]         burst_cnt;
  logic                  fire;
  logic                  rel;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] din;
  // First valid index after 'from' (wrapping); 'from' itself has the lowest priority.
  function automatic logic [ID_WIDTH-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [ID_WIDTH-1:0] from);
    int best;
    int d;
    pick = from;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(from)) % NUM_REQ;
      if (v[i] && d < best) begin
        best = d;
        pick = ID_WIDTH'(i);
      end
    end
  endfunction
  always_comb begin
    fire = state == GRANT && bus.req_valid[grant_id] && !bus.fifo_full;
    rel = state == GRANT && (!bus.req_valid[grant_id] || (fire && burst_cnt == CW'(MAX_BURST - 1)));
    ready = '0;
    din = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (fire && grant_id == ID_WIDTH'(i)) begin
        ready[i] = 1'b1;
        din = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  assign bus.req_ready  = ready;
  assign bus.fifo_wr_en = fire;
  assign bus.fifo_din   = din;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = state == GRANT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_id   <= ID_WIDTH'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (|bus.req_valid) begin
        state     <= GRANT;
        grant_id  <= pick(bus.req_valid, last_id);
        burst_cnt <= '0;
      end
    end else if (rel) begin
      // Re-arbitrate in the release cycle so a waiting requester (or the holder) is granted without a gap.
      last_id   <= grant_id;
      burst_cnt <= '0;
      if (|bus.req_valid) grant_id <= pick(bus.req_valid, grant_id);
      else state <= IDLE;
    end else if (fire) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
endmodule
